// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame length helper and the rw-bit encoding
// that the host master and the accelerator's slave decoder both rely on.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    END   = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response handshake plus the four SPI wires of the host-side master.
interface spi_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, miso,
    output req_ready, rsp_valid, rsp_rdata, sclk, cs_n, mosi
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, miso,
    input  req_ready, rsp_valid, rsp_rdata, sclk, cs_n, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: restarts whenever the FSM changes state and flags
// the CLK_DIV-th cycle spent in that state.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_r;

  // counter saturates on the terminal value so it can never wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= CNT_W'(0);
    end else if (restart) begin
      cnt_r <= CNT_W'(0);
    end else if (cnt_r != CNT_W'(CLK_DIV - 1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_master.sv
// Host-side SPI master (mode 0, MSB first): one {rw, addr, data} frame per
// accepted request, read data returned on a single-cycle response strobe.
module spi_master
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int FRAME = frame_len(ADDR_W, DATA_W);
  localparam int BIT_W = $clog2(FRAME + 1);

  spi_state_e        state_r;
  spi_state_e        state_s;
  logic [FRAME-1:0]  shreg_r;
  logic [DATA_W-1:0] rx_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              rw_r;
  logic              tick_s;
  logic              accept_s;
  logic              restart_s;
  logic              busy_s;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              sclk_r;
  logic              cs_n_r;
  logic              mosi_r;

  assign accept_s  = (state_r == IDLE) && bus.req_valid && req_ready_r;
  assign restart_s = (state_s != state_r);
  assign busy_s    = (state_r == SETUP) || (state_r == HIGH) || (state_r == LOW);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = SETUP; else state_s = IDLE;
      SETUP:   if (tick_s) state_s = HIGH; else state_s = SETUP;
      HIGH:    if (tick_s) state_s = LOW; else state_s = HIGH;
      LOW: begin
        if (!tick_s) begin
          state_s = LOW;
        end else if (bit_cnt_r != BIT_W'(0)) begin
          state_s = HIGH;
        end else begin
          state_s = END;
        end
      end
      END:     state_s = GAP;
      GAP:     if (tick_s) state_s = IDLE; else state_s = GAP;
      default: state_s = IDLE;
    endcase
  end

  // state register, shift/receive registers and bit counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      shreg_r   <= {FRAME{1'b0}};
      rx_r      <= {DATA_W{1'b0}};
      bit_cnt_r <= BIT_W'(0);
      rw_r      <= RW_READ;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        shreg_r   <= {bus.req_rw, bus.req_addr,
                      (bus.req_rw == RW_WRITE) ? bus.req_wdata : {DATA_W{1'b0}}};
        bit_cnt_r <= BIT_W'(FRAME);
        rw_r      <= bus.req_rw;
      end else if ((state_r == HIGH) && tick_s) begin
        shreg_r   <= {shreg_r[FRAME-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r - BIT_W'(1);
        rx_r      <= {rx_r[DATA_W-2:0], bus.miso};
      end
    end
  end

  // outputs are registered from the current state, so the pins trail the FSM by one cycle;
  // req_ready alone follows the next state so it drops on the very edge that accepts
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      sclk_r      <= 1'b0;
      cs_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_r == END);
      sclk_r      <= (state_r == HIGH);
      cs_n_r      <= !busy_s;
      mosi_r      <= busy_s ? shreg_r[FRAME-1] : 1'b0;
      if (state_r == END) begin
        rsp_rdata_r <= (rw_r == RW_READ) ? rx_r : {DATA_W{1'b0}};
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.sclk      = sclk_r;
  assign bus.cs_n      = cs_n_r;
  assign bus.mosi      = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=2 with a mode-0 slave model,
// one at CLK_DIV=1 for the fastest-clock frame.
module tb_spi_master;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if2 ();
  spi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();

  spi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2));
  spi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] slave_word = 32'h0;

  // monitor state for the CLK_DIV=2 instance
  int cyc = 0, e2 = 0, csl2 = 0, rsp2 = 0, acc2 = 0, rsp2_cyc = 0, acc2_cyc = 0, acc2_gap = 0;
  int rdy_cs2 = 0, csh2_run = 0, gap2 = 0, frm2 = 0, run2 = 0, min_stab2 = 1000;
  logic        sclk2_q = 1'b0, cs2_q = 1'b1, mosi2_q = 1'b0;
  logic [63:0] mh2 = 64'h0;
  logic [31:0] rd2 = 32'h0;

  // monitor state for the CLK_DIV=1 instance
  int e1 = 0, csl1 = 0, sh1 = 0, rsp1 = 0, rsp1_cyc = 0, acc1_cyc = 0;
  logic        sclk1_q = 1'b0;
  logic [63:0] mh1 = 64'h0;
  logic [31:0] rd1 = 32'h0;

  // sample away from the active edge; the slave model changes miso after each sclk fall
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sclk2_q <= if2.sclk;
    cs2_q   <= if2.cs_n;
    mosi2_q <= if2.mosi;
    run2    <= (if2.mosi === mosi2_q) ? run2 + 1 : 1;
    if (if2.sclk === 1'b1 && sclk2_q === 1'b0) begin
      e2  <= e2 + 1;
      mh2 <= {mh2[62:0], if2.mosi};
      if (((if2.mosi === mosi2_q) ? run2 : 0) < min_stab2)
        min_stab2 <= (if2.mosi === mosi2_q) ? run2 : 0;
    end
    if (if2.cs_n !== 1'b0) begin
      frm2     <= 0;
      if2.miso <= 1'b0;
    end else begin
      if (if2.sclk === 1'b1 && sclk2_q === 1'b0) frm2 <= frm2 + 1;
      if (if2.sclk === 1'b0 && sclk2_q === 1'b1)
        if2.miso <= (frm2 >= 17 && frm2 < 49) ? slave_word[5'(48 - frm2)] : 1'b0;
    end
    if (if2.cs_n === 1'b0) csl2 <= csl2 + 1;
    if (if2.cs_n === 1'b0 && if2.req_ready === 1'b1) rdy_cs2 <= rdy_cs2 + 1;
    csh2_run <= (if2.cs_n === 1'b1) ? csh2_run + 1 : 0;
    if (if2.cs_n === 1'b0 && cs2_q === 1'b1) gap2 <= csh2_run;
    if (if2.rsp_valid === 1'b1) begin
      rsp2     <= rsp2 + 1;
      rsp2_cyc <= cyc;
      rd2      <= if2.rsp_rdata;
    end
    if (if2.req_valid === 1'b1 && if2.req_ready === 1'b1) begin
      acc2     <= acc2 + 1;
      acc2_cyc <= cyc;
      acc2_gap <= cyc - rsp2_cyc;
    end
    sclk1_q <= if1.sclk;
    if (if1.sclk === 1'b1 && sclk1_q === 1'b0) begin
      e1  <= e1 + 1;
      mh1 <= {mh1[62:0], if1.mosi};
    end
    if (if1.cs_n === 1'b0) csl1 <= csl1 + 1;
    if (if1.cs_n === 1'b0 && if1.sclk === 1'b1) sh1 <= sh1 + 1;
    if (if1.rsp_valid === 1'b1) begin
      rsp1     <= rsp1 + 1;
      rsp1_cyc <= cyc;
      rd1      <= if1.rsp_rdata;
    end
    if (if1.req_valid === 1'b1 && if1.req_ready === 1'b1) acc1_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start2(input logic rw, input logic [15:0] a, input logic [31:0] d);
    for (int i = 0; i < 50 && if2.req_ready !== 1'b1; i++) begin @(posedge clk); #1; end
    check("ready_wait2", if2.req_ready, 64'd1);
    if2.req_valid = 1'b1; if2.req_rw = rw; if2.req_addr = a; if2.req_wdata = d;
    @(posedge clk); #1;
    if2.req_valid = 1'b0; if2.req_rw = ~rw; if2.req_addr = ~a; if2.req_wdata = ~d;
  endtask

  task automatic wait_rsp2(input int tgt);
    for (int i = 0; i < 1000 && rsp2 < tgt; i++) begin @(posedge clk); #1; end
    check("rsp_wait2", 64'(rsp2 >= tgt), 64'd1);
  endtask

  int e0, c0, r0, a0, h0, k0;

  initial begin
    if2.req_valid = 1'b0; if2.req_rw = 1'b0; if2.req_addr = 16'h0; if2.req_wdata = 32'h0;
    if1.req_valid = 1'b0; if1.req_rw = 1'b0; if1.req_addr = 16'h0; if1.req_wdata = 32'h0;
    if1.miso = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ready", if2.req_ready, 64'd0);
    check("rst_cs_n", if2.cs_n, 64'd1);
    check("rst_sclk", if2.sclk, 64'd0);
    check("rst_mosi", if2.mosi, 64'd0);
    check("rst_rsp_valid", if2.rsp_valid, 64'd0);
    check("rst_rsp_rdata", if2.rsp_rdata, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", if2.req_ready, 64'd1);

    r0 = rsp2; c0 = csl2;
    repeat (20) @(posedge clk);
    #1;
    check("idle_rsp", 64'(rsp2 - r0), 64'd0);
    check("idle_cs_low", 64'(csl2 - c0), 64'd0);
    check("idle_cs_n", if2.cs_n, 64'd1);
    check("idle_sclk", if2.sclk, 64'd0);
    check("idle_ready", if2.req_ready, 64'd1);

    // write frame at CLK_DIV=2
    e0 = e2; c0 = csl2; r0 = rsp2;
    start2(1'b1, 16'h5555, 32'hDEADBEEF);
    wait_rsp2(r0 + 1);
    check("wr_edges", 64'(e2 - e0), 64'd49);
    check("wr_mosi", mh2[48:0], {1'b1, 16'h5555, 32'hDEADBEEF});
    check("wr_cs_low", 64'(csl2 - c0), 64'd198);
    check("wr_rsp_latency", 64'(rsp2_cyc - acc2_cyc), 64'd200);
    check("wr_rdata", rd2, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("wr_rsp_pulses", 64'(rsp2 - r0), 64'd1);

    // read frame: slave returns 0x12345678
    slave_word = 32'h12345678;
    r0 = rsp2;
    start2(1'b0, 16'h0010, 32'hFFFFFFFF);
    wait_rsp2(r0 + 1);
    check("rd_mosi", mh2[48:0], {1'b0, 16'h0010, 32'h0});
    check("rd_rdata", rd2, 64'h12345678);
    repeat (5) @(posedge clk);
    #1;
    check("rd_rdata_hold", if2.rsp_rdata, 64'h12345678);

    // two requests with req_valid held high
    for (int i = 0; i < 50 && if2.req_ready !== 1'b1; i++) begin @(posedge clk); #1; end
    slave_word = 32'hCAFEF00D;
    a0 = acc2; r0 = rsp2; k0 = rdy_cs2;
    if2.req_valid = 1'b1; if2.req_rw = 1'b1; if2.req_addr = 16'h00A1; if2.req_wdata = 32'h11111111;
    for (int i = 0; i < 50 && acc2 < a0 + 1; i++) @(posedge clk);
    #1;
    if2.req_rw = 1'b0; if2.req_addr = 16'h00A2;
    for (int i = 0; i < 1000 && acc2 < a0 + 2; i++) @(posedge clk);
    #1;
    if2.req_valid = 1'b0;
    check("b2b_accepts", 64'(acc2 - a0), 64'd2);
    wait_rsp2(r0 + 2);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_rsp_pulses", 64'(rsp2 - r0), 64'd2);
    check("b2b_ready_in_frame", 64'(rdy_cs2 - k0), 64'd0);
    check("b2b_cs_gap", 64'(gap2 >= 3), 64'd1);
    check("b2b_accept_gap", 64'(acc2_gap), 64'd2);
    check("b2b_rdata", rd2, 64'hCAFEF00D);
    check("b2b_mosi", mh2[48:0], {1'b0, 16'h00A2, 32'h0});

    // reset in the middle of a frame
    r0 = rsp2; e0 = e2;
    start2(1'b1, 16'h0F0F, 32'h0);
    for (int i = 0; i < 200 && (e2 - e0) < 20; i++) begin @(posedge clk); #1; end
    check("abort_edge_wait", 64'((e2 - e0) >= 20), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_cs_n", if2.cs_n, 64'd1);
    check("abort_sclk", if2.sclk, 64'd0);
    check("abort_ready", if2.req_ready, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(rsp2 - r0), 64'd0);
    e0 = e2;
    start2(1'b1, 16'h1234, 32'hA5A5A5A5);
    wait_rsp2(r0 + 1);
    check("post_abort_edges", 64'(e2 - e0), 64'd49);
    check("post_abort_mosi", mh2[48:0], {1'b1, 16'h1234, 32'hA5A5A5A5});
    check("post_abort_rdata", rd2, 64'd0);

    // CLK_DIV=1 write
    e0 = e1; c0 = csl1; h0 = sh1; r0 = rsp1;
    for (int i = 0; i < 50 && if1.req_ready !== 1'b1; i++) begin @(posedge clk); #1; end
    if1.req_valid = 1'b1; if1.req_rw = 1'b1; if1.req_addr = 16'h8001; if1.req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    if1.req_valid = 1'b0; if1.req_wdata = 32'h0;
    for (int i = 0; i < 500 && rsp1 < r0 + 1; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    check("div1_rsp", 64'(rsp1 - r0), 64'd1);
    check("div1_edges", 64'(e1 - e0), 64'd49);
    check("div1_cs_low", 64'(csl1 - c0), 64'd99);
    check("div1_sclk_high", 64'(sh1 - h0), 64'd49);
    check("div1_rsp_latency", 64'(rsp1_cyc - acc1_cyc), 64'd101);
    check("div1_mosi", mh1[48:0], {1'b1, 16'h8001, 32'hFFFFFFFF});
    check("div1_rdata", rd1, 64'd0);

    check("mosi_setup_min", 64'(min_stab2 >= 2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI master that issues single-word register transactions to the accelerator's SPI slave port. It accepts one read or write request per handshake and serialises it as a fixed-length frame of {rw, addr, data} in SPI mode 0, MSB first. For reads it captures MISO and returns the word on a single-cycle response strobe. It is used in the FPGA host bridge and as the active driver in accelerator-level benches.

## Interface
- ADDR_W, 16, address field width
- DATA_W, 32, data field width
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_rw  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse at end of every transaction
- rsp_rdata  out  DATA_W  captured read data; 0 for writes
- sclk  out  1  SPI clock, idle low
- cs_n  out  1  chip select, active low
- mosi  out  1  serial out
- miso  in  1  serial in

## Operation
- FRAME = 1 + ADDR_W + DATA_W bits. The shift register loads {req_rw, req_addr, wdata_or_zero} on accept; read frames send zeros in the data field.
- States and transitions:
  - IDLE → SETUP on req_valid && req_ready.
  - SETUP → HIGH after CLK_DIV cycles.
  - HIGH → LOW after CLK_DIV cycles.
  - LOW → HIGH after CLK_DIV cycles while bits remain. After the last bit, LOW → END.
  - END → GAP after 1 cycle.
  - GAP → IDLE after CLK_DIV cycles.
- SETUP: cs_n=0, sclk=0, mosi = frame bit FRAME-1.
- HIGH: sclk=1. On the last clk cycle of HIGH, miso is shifted into the receive register. The bit counter decrements on entering LOW.
- LOW: sclk=0. mosi presents the next bit from the first LOW cycle onward. The last LOW phase serves as CS hold.
- END: cs_n=1, rsp_valid=1. rsp_rdata = low DATA_W received bits if the frame was a read, else 0. rsp_rdata holds its value until the next END.
- GAP: cs_n=1, req_ready=0. This guarantees minimum CS-high time.
- Request inputs are sampled only at accept. Changes during a transaction are ignored.
- No abort path: a transaction always completes unless reset.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after release. rsp_valid=0, rsp_rdata=0, sclk=0, cs_n=1, mosi=0. State = IDLE.
- Reset mid-frame: on the next clk edge cs_n=1 and sclk=0. No rsp_valid is issued and the partial frame is discarded.
- Accept at edge T, so cs_n falls at T+1. cs_n stays low for CLK_DIV·(2·FRAME+1) cycles.
- rsp_valid occurs at T+1+CLK_DIV·(2·FRAME+1). The next accept is possible CLK_DIV+1 cycles after rsp_valid.
- Back-to-back req_valid: the second request waits; req_ready rises only on return to IDLE.
- Exactly FRAME SCLK rising edges per frame. MOSI is stable for ≥CLK_DIV cycles before each rising edge.
- Counter widths:
  - Half-period counter: $clog2(CLK_DIV+1).
  - Bit counter: $clog2(FRAME+1).
  - Neither counter may wrap.

## Structure
- spi_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, END, GAP);
  - the frame_len(ADDR_W, DATA_W) function;
  - RW_WRITE=1 / RW_READ=0 constants, shared with the SPI slave decoder.
- One sub-module, spi_clk_div: a half-period tick generator that restarts on state change and emits a one-cycle tick after CLK_DIV cycles.

## Test plan
- Reset then idle 20 cycles: cs_n=1, sclk=0, req_ready=1, rsp_valid never asserted.
- Write, CLK_DIV=2, addr 16'h5555, data 32'hDEADBEEF:
  - MOSI at the 49 rising edges = 1, 0x5555, 0xDEADBEEF (MSB first);
  - cs_n low 198 cycles;
  - rsp_valid at T+199 with rsp_rdata=0.
- Read, addr 16'h0010, with the slave model driving 32'h12345678 on the falling edges of the data phase: MOSI data bits all 0; rsp_rdata=32'h12345678.
- Two requests with req_valid held high:
  - req_ready low throughout the first transaction;
  - cs_n high for ≥CLK_DIV+1 cycles between frames;
  - exactly two rsp_valid pulses, one per request.
- Reset asserted at the 20th SCLK edge: next cycle cs_n=1, sclk=0; no rsp_valid; a fresh write after release completes correctly.
- CLK_DIV=1 write of 32'hFFFFFFFF: 49 SCLK edges; high and low phases each exactly 1 cycle.
